// File: rtl/dual_rail_unloader.sv
// Receiver for the 16-cell dual-rail load bus: waits for a stable, complete word,
// hands it off over valid/ready, and counts illegal-code episodes.
module dual_rail_unloader #(
   parameter int STABLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:32]      bus,
   output logic [1:16]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      S_WAIT_SPACER,
      S_ARMED,
      S_SETTLE,
      S_DELIVER,
      S_ERROR
   } state_t;

   localparam logic [3:0] C_LAST = 4'(STABLE_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:32]        r_bus_q;
   logic               r_primed;
   logic [1:16]        r_latch;
   logic [3:0]         r_cnt;
   logic [1:16]        r_out_data;
   logic               r_out_valid;
   logic               r_err;
   logic [ERR_W-1:0]   r_err_cnt;

   logic [1:16]        w_dec;
   logic               w_any_ill;
   logic               w_all_sp_raw;
   logic               w_complete;
   logic               w_spacer;
   logic [3:0]         w_cnt_nxt;
   logic               w_load_latch;
   logic               w_deliver;
   logic               w_accept;
   logic               w_err_set;
   logic               w_err_clr;

   always_comb begin
      w_dec        = '0;
      w_any_ill    = 1'b0;
      w_all_sp_raw = 1'b1;
      w_complete   = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         w_dec[k] = r_bus_q[2*k-1];
         if (r_bus_q[2*k-1] & r_bus_q[2*k])   w_any_ill    = 1'b1;
         if (r_bus_q[2*k-1] | r_bus_q[2*k])   w_all_sp_raw = 1'b0;
         if (r_bus_q[2*k-1] == r_bus_q[2*k])  w_complete   = 1'b0;
      end
   end

   // The zero left in r_bus_q by reset is not a real sample, so it must not arm us.
   assign w_spacer = w_all_sp_raw & r_primed;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_load_latch = 1'b0;
      w_deliver    = 1'b0;
      w_accept     = 1'b0;
      w_err_set    = 1'b0;
      w_err_clr    = 1'b0;
      case (r_state)
         S_WAIT_SPACER: begin
            if (w_any_ill) begin
               w_state_nxt = S_ERROR;
               w_err_set   = 1'b1;
            end else if (w_spacer) begin
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (w_any_ill) begin
               w_state_nxt = S_ERROR;
               w_err_set   = 1'b1;
            end else if (w_complete) begin
               w_state_nxt  = S_SETTLE;
               w_load_latch = 1'b1;
               w_cnt_nxt    = 4'd1;
            end
         end
         S_SETTLE: begin
            if (w_any_ill) begin
               w_state_nxt = S_ERROR;
               w_err_set   = 1'b1;
            end else if (w_complete) begin
               if (w_dec != r_latch) begin
                  w_load_latch = 1'b1;
                  w_cnt_nxt    = 4'd1;
               end else if (r_cnt == C_LAST) begin
                  w_state_nxt = S_DELIVER;
                  w_deliver   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end else begin
               w_state_nxt = S_ARMED;
               w_cnt_nxt   = 4'd0;
            end
         end
         S_DELIVER: begin
            if (out_ready) begin
               w_state_nxt = S_WAIT_SPACER;
               w_accept    = 1'b1;
            end
         end
         S_ERROR: begin
            if (w_spacer) begin
               w_state_nxt = S_ARMED;
               w_err_clr   = 1'b1;
            end
         end
         default: w_state_nxt = S_WAIT_SPACER;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_WAIT_SPACER;
         r_bus_q     <= '0;
         r_primed    <= 1'b0;
         r_latch     <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_bus_q  <= bus;
         r_primed <= 1'b1;
         r_cnt    <= w_cnt_nxt;
         if (w_load_latch) r_latch <= w_dec;
         if (w_deliver) begin
            r_out_data  <= r_latch;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
         end else if (w_err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dual_rail_unloader.sv
// Directed bench for dual_rail_unloader: expected words go into a queue, and a
// negedge monitor checks every handshake against it.
module tb_dual_rail_unloader;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [1:32]  bus = '0;
   logic [1:16]  out_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         err;
   logic [7:0]   err_cnt;

   int           total = 0;
   int           bad   = 0;
   logic [15:0]  exp_q[$];
   logic [15:0]  mon_exp;
   logic         seen_valid;

   dual_rail_unloader #(.STABLE_CYCLES(2), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [1:32] enc(input logic [15:0] v);
      logic [1:32] b;
      for (int k = 1; k <= 16; k++) begin
         b[2*k-1] = v[16-k];
         b[2*k]   = ~v[16-k];
      end
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sticky out_valid watch over n cycles.
   task automatic idle(input int n);
      seen_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (out_valid) seen_valid = 1'b1;
      end
   endtask

   task automatic wait_valid(input string nm, input int exp_lat);
      int n;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            n = i;
            break;
         end
      end
      chk(nm, n, exp_lat);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_err", err, 0);
      chk("rst_errcnt", err_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_delivery: got %0h expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp) begin
               bad++;
               $display("FAIL delivered_word: got %0h expected %0h", out_data, mon_exp);
            end
         end
      end
   end

   initial begin
      // Basic delivery with latency and drop after acceptance
      #2;
      pulse_reset();
      bus = '0;
      tick(2);
      bus = enc(16'hA5C3);
      exp_q.push_back(16'hA5C3);
      wait_valid("lat_a5c3", 3);
      chk("data_a5c3", out_data, 16'hA5C3);
      tick(1);
      chk("drop_after_accept", out_valid, 0);
      idle(2);
      chk("no_redeliver", seen_valid, 0);
      bus = '0;
      tick(2);

      // Bus carrying data across reset release
      bus = enc(16'h1234);
      pulse_reset();
      idle(10);
      chk("no_deliver_at_release", seen_valid, 0);
      bus = '0;
      tick(2);
      bus = enc(16'h1234);
      exp_q.push_back(16'h1234);
      wait_valid("lat_1234", 3);
      tick(2);
      bus = '0;
      tick(2);

      // One-cycle glitch word followed by a stable one
      bus = enc(16'h00FF);
      tick(1);
      bus = enc(16'h0F0F);
      exp_q.push_back(16'h0F0F);
      wait_valid("lat_0f0f", 3);
      chk("data_0f0f", out_data, 16'h0F0F);
      tick(1);
      bus = '0;
      tick(2);

      // Illegal pair 7 while armed
      bus = '0;
      bus[13] = 1'b1;
      bus[14] = 1'b1;
      tick(3);
      chk("err_set", err, 1);
      chk("err_cnt_1", err_cnt, 1);
      bus[14] = 1'b0;
      tick(3);
      chk("err_held_partial", err, 1);
      chk("err_cnt_still_1", err_cnt, 1);
      bus = '0;
      tick(2);
      chk("err_cleared", err, 0);
      for (int i = 0; i < 300; i++) begin
         bus = 32'hFFFF_FFFF;
         tick(3);
         bus = '0;
         tick(2);
      end
      chk("err_cnt_sat", err_cnt, 255);
      chk("err_clear_after_sat", err, 0);

      // Held delivery with bus activity underneath
      out_ready = 1'b0;
      bus = enc(16'hFFFF);
      exp_q.push_back(16'hFFFF);
      wait_valid("lat_ffff", 3);
      for (int i = 0; i < 6; i++) begin
         bus = (i % 2 == 0) ? enc(16'h0000) : 32'hFFFF_FFFF;
         tick(1);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 16'hFFFF);
         chk("hold_err", err, 0);
      end
      bus = enc(16'h1111);
      out_ready = 1'b1;
      tick(1);
      chk("accept_ffff", out_valid, 0);
      idle(5);
      chk("needs_spacer", seen_valid, 0);
      bus = '0;
      tick(2);
      bus = enc(16'h2222);
      exp_q.push_back(16'h2222);
      wait_valid("lat_2222", 3);
      tick(1);
      bus = '0;
      tick(2);

      // Reset during SETTLE
      bus = enc(16'h5A5A);
      tick(2);
      pulse_reset();
      idle(6);
      chk("no_deliver_after_settle_rst", seen_valid, 0);
      bus = '0;
      tick(2);
      bus = enc(16'h5A5A);
      exp_q.push_back(16'h5A5A);
      wait_valid("lat_5a5a", 3);
      tick(1);
      bus = '0;
      tick(2);

      // Reset during DELIVER
      out_ready = 1'b0;
      bus = enc(16'h3C3C);
      wait_valid("lat_3c3c_pre", 3);
      pulse_reset();
      out_ready = 1'b1;
      idle(6);
      chk("no_deliver_after_deliver_rst", seen_valid, 0);
      bus = '0;
      tick(2);
      bus = enc(16'h3C3C);
      exp_q.push_back(16'h3C3C);
      wait_valid("lat_3c3c", 3);
      tick(2);

      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
